// File: rtl/duck_flight_ctrl.sv
// Duck position generator: bouncing LFSR-perturbed flight while hunting,
// freeze on hit, fall below the grass line, respawn on the next hunt.
module duck_flight_ctrl #(
  parameter int unsigned SCREEN_W   = 1024,
  parameter int unsigned GROUND_Y   = 600,
  parameter int unsigned DUCK_W     = 96,
  parameter int unsigned DUCK_H     = 60,
  parameter int unsigned STEP_TICKS = 650_000,
  parameter int unsigned X_STEP     = 4,
  parameter int unsigned Y_STEP     = 3,
  parameter int unsigned FALL_STEP  = 6,
  parameter int unsigned HIT_STEPS  = 50,
  parameter int unsigned START_X    = 464,
  parameter int unsigned START_Y    = 520,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hunt_start,
  input  logic        duck_killed,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic        duck_face_right,
  output logic        duck_falling,
  output logic        duck_visible,
  output logic        duck_landed
);

  localparam int unsigned CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - DUCK_W);
  localparam logic signed [12:0] Y_MAX = 13'(GROUND_Y - DUCK_H);

  typedef enum logic [2:0] {IDLE, FLYING, HIT, FALLING, DOWN} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   tick_cnt;
  logic [7:0]         step_cnt, step_cnt_n;
  logic [15:0]        lfsr;
  logic               hunt_prev, vert_up, vert_up_n, face_n, landed_n;
  logic [11:0]        x_n, y_n;
  logic               step, hunt_rise;
  logic signed [12:0] x_t, y_t;
  logic [12:0]        y_f;

  assign step      = (tick_cnt == CNT_W'(STEP_TICKS - 1));
  assign hunt_rise = hunt_start & ~hunt_prev;

  always_comb begin
    state_n    = state;
    x_n        = duck_xpos;
    y_n        = duck_ypos;
    face_n     = duck_face_right;
    vert_up_n  = vert_up;
    step_cnt_n = step_cnt;
    landed_n   = 1'b0;
    x_t        = '0;
    y_t        = '0;
    y_f        = {1'b0, duck_ypos} + 13'(FALL_STEP);
    case (state)
      IDLE, DOWN: begin
        if (hunt_rise) begin
          state_n    = FLYING;
          x_n        = 12'(START_X);
          y_n        = 12'(START_Y);
          face_n     = lfsr[0];
          vert_up_n  = 1'b1;
          step_cnt_n = '0;
        end
      end
      FLYING: begin
        if (duck_killed) begin
          state_n    = HIT;
          step_cnt_n = '0;
        end else if (hunt_start && step) begin
          x_t = duck_face_right ? $signed({1'b0, duck_xpos}) + $signed(13'(X_STEP))
                                : $signed({1'b0, duck_xpos}) - $signed(13'(X_STEP));
          if (x_t < 13'sd0) begin
            x_n    = '0;
            face_n = 1'b1;
          end else if (x_t > X_MAX) begin
            x_n    = X_MAX[11:0];
            face_n = 1'b0;
          end else begin
            x_n = x_t[11:0];
          end
          y_t = vert_up ? $signed({1'b0, duck_ypos}) - $signed(13'(Y_STEP))
                        : $signed({1'b0, duck_ypos}) + $signed(13'(Y_STEP));
          if (y_t < 13'sd0) begin
            y_n       = '0;
            vert_up_n = 1'b0;
          end else if (y_t > Y_MAX) begin
            y_n       = Y_MAX[11:0];
            vert_up_n = 1'b1;
          end else begin
            y_n = y_t[11:0];
          end
          // Random wobble applied after the bounce so it may override it
          if (step_cnt[3:0] == 4'hF) vert_up_n = vert_up_n ^ lfsr[1];
          step_cnt_n = step_cnt + 8'd1;
        end
      end
      HIT: begin
        if (step) begin
          if (step_cnt == 8'(HIT_STEPS - 1)) state_n = FALLING;
          else step_cnt_n = step_cnt + 8'd1;
        end
      end
      FALLING: begin
        if (step) begin
          if (y_f >= 13'(GROUND_Y)) begin
            y_n      = 12'(GROUND_Y);
            landed_n = 1'b1;
            state_n  = DOWN;
          end else begin
            y_n = y_f[11:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      duck_xpos       <= 12'(START_X);
      duck_ypos       <= 12'(GROUND_Y);
      duck_face_right <= 1'b1;
      vert_up         <= 1'b1;
      duck_falling    <= 1'b0;
      duck_visible    <= 1'b0;
      duck_landed     <= 1'b0;
      tick_cnt        <= '0;
      step_cnt        <= '0;
      hunt_prev       <= 1'b0;
      lfsr            <= LFSR_SEED;
    end else begin
      state           <= state_n;
      duck_xpos       <= x_n;
      duck_ypos       <= y_n;
      duck_face_right <= face_n;
      vert_up         <= vert_up_n;
      duck_falling    <= (state_n == HIT) || (state_n == FALLING);
      duck_visible    <= (state_n != IDLE);
      duck_landed     <= landed_n;
      tick_cnt        <= step ? '0 : tick_cnt + CNT_W'(1);
      step_cnt        <= step_cnt_n;
      hunt_prev       <= hunt_start;
      lfsr            <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Directed bench for duck_flight_ctrl with short step period and a spawn point
// close to the top-left corner so both wall bounces are reached in a few steps.
module tb_duck_flight_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, hunt_start, duck_killed;
  logic [11:0] duck_xpos, duck_ypos;
  logic        duck_face_right, duck_falling, duck_visible, duck_landed;

  int   checks = 0;
  int   failures = 0;
  bit   phase;
  logic [15:0] tb_lfsr;

  duck_flight_ctrl #(
    .STEP_TICKS(2),
    .HIT_STEPS (3),
    .START_X   (10),
    .START_Y   (14)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hunt_start     (hunt_start),
    .duck_killed    (duck_killed),
    .duck_xpos      (duck_xpos),
    .duck_ypos      (duck_ypos),
    .duck_face_right(duck_face_right),
    .duck_falling   (duck_falling),
    .duck_visible   (duck_visible),
    .duck_landed    (duck_landed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // phase mirrors the step tick counter: a motion step happens on edges where it returns to 0
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      phase   = 1'b0;
      tb_lfsr = SEED;
    end else begin
      phase   = ~phase;
      tb_lfsr = lfsr_adv(tb_lfsr);
    end
    #1;
  endtask

  task automatic next_step();
    tick();
    if (phase) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int ex[6] = '{6, 2, 0, 4, 8, 12};
  int ey[6] = '{11, 8, 5, 2, 0, 3};
  int ef[6] = '{0, 0, 1, 1, 1, 1};
  int exp_y;
  bit exp_face;
  bit landed_seen;

  initial begin
    rst = 1'b1; hunt_start = 1'b0; duck_killed = 1'b0;
    repeat (3) tick();
    chk("rst_x", duck_xpos, 10);
    chk("rst_y", duck_ypos, 600);
    chk("rst_vis", duck_visible, 0);
    chk("rst_fall", duck_falling, 0);
    chk("rst_face", duck_face_right, 1);
    chk("rst_land", duck_landed, 0);
    rst = 1'b0;

    // spawn facing left: wait for an LFSR value with bit0 clear
    for (int i = 0; i < 64 && tb_lfsr[0]; i++) tick();
    chk("seed_even", tb_lfsr[0], 0);
    hunt_start = 1'b1;
    tick();
    chk("spawn_x", duck_xpos, 10);
    chk("spawn_y", duck_ypos, 14);
    chk("spawn_vis", duck_visible, 1);
    chk("spawn_face", duck_face_right, 0);

    for (int i = 0; i < 6; i++) begin
      next_step();
      chk($sformatf("fly_x%0d", i), duck_xpos, ex[i]);
      chk($sformatf("fly_y%0d", i), duck_ypos, ey[i]);
      chk($sformatf("fly_face%0d", i), duck_face_right, ef[i]);
    end

    hunt_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_step();
      chk("pause_x", duck_xpos, 12);
      chk("pause_y", duck_ypos, 3);
    end
    hunt_start = 1'b1;
    tick();
    chk("resume_noresp_x", duck_xpos, 12);
    duck_killed = 1'b1;
    tick();
    duck_killed = 1'b0;
    chk("kill_phase", phase, 0);
    chk("kill_x", duck_xpos, 12);
    chk("kill_y", duck_ypos, 3);
    chk("kill_fall", duck_falling, 1);

    for (int i = 0; i < 3; i++) begin
      next_step();
      chk("hit_y", duck_ypos, 3);
      chk("hit_fall", duck_falling, 1);
    end

    exp_y = 3;
    landed_seen = 0;
    for (int i = 0; i < 120 && !landed_seen; i++) begin
      next_step();
      exp_y = (exp_y + 6 >= 600) ? 600 : exp_y + 6;
      chk("fall_y", duck_ypos, exp_y);
      if (exp_y == 600) begin
        landed_seen = 1;
        chk("land_pulse", duck_landed, 1);
        chk("land_fall", duck_falling, 0);
        chk("land_x", duck_xpos, 12);
      end else begin
        chk("fall_flag", duck_falling, 1);
      end
    end
    chk("land_reached", landed_seen, 1);
    tick();
    chk("land_single", duck_landed, 0);
    chk("down_vis", duck_visible, 1);

    duck_killed = 1'b1;
    tick();
    duck_killed = 1'b0;
    next_step();
    chk("down_kill_fall", duck_falling, 0);
    chk("down_kill_y", duck_ypos, 600);

    hunt_start = 1'b0;
    tick();
    hunt_start = 1'b1;
    exp_face = tb_lfsr[0];
    tick();
    chk("respawn_x", duck_xpos, 10);
    chk("respawn_y", duck_ypos, 14);
    chk("respawn_face", duck_face_right, exp_face);

    duck_killed = 1'b1;
    tick();
    duck_killed = 1'b0;
    chk("kill2_fall", duck_falling, 1);
    repeat (5) next_step();
    chk("fall2_y", duck_ypos, 26);
    chk("fall2_flag", duck_falling, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_x", duck_xpos, 10);
    chk("rst2_y", duck_ypos, 600);
    chk("rst2_vis", duck_visible, 0);
    chk("rst2_fall", duck_falling, 0);
    chk("rst2_face", duck_face_right, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
